// File: rtl/juego_pkg.sv
// Shared definitions for the hero game: keypad codes, keypad debounce states
// and top-level game states.
package juego_pkg;

    localparam logic [4:0] KEY_0    = 5'd0;
    localparam logic [4:0] KEY_1    = 5'd1;
    localparam logic [4:0] KEY_2    = 5'd2;
    localparam logic [4:0] KEY_3    = 5'd3;
    localparam logic [4:0] KEY_4    = 5'd4;
    localparam logic [4:0] KEY_5    = 5'd5;
    localparam logic [4:0] KEY_6    = 5'd6;
    localparam logic [4:0] KEY_7    = 5'd7;
    localparam logic [4:0] KEY_8    = 5'd8;
    localparam logic [4:0] KEY_9    = 5'd9;
    localparam logic [4:0] KEY_A    = 5'd10;
    localparam logic [4:0] KEY_B    = 5'd11;
    localparam logic [4:0] KEY_C    = 5'd12;
    localparam logic [4:0] KEY_D    = 5'd13;
    localparam logic [4:0] KEY_STAR = 5'd14;
    localparam logic [4:0] KEY_HASH = 5'd15;

    typedef enum logic [1:0] {
        REL          = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } deb_state_t;

    typedef enum logic [1:0] {
        apagado   = 2'd0,
        hola      = 2'd1,
        personaje = 2'd2,
        juego     = 2'd3
    } game_state_t;

    // Physical layout: rows top to bottom, columns left to right.
    function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [4:0] code;
        case ({r, c})
            4'h0: code = KEY_1;
            4'h1: code = KEY_2;
            4'h2: code = KEY_3;
            4'h3: code = KEY_A;
            4'h4: code = KEY_4;
            4'h5: code = KEY_5;
            4'h6: code = KEY_6;
            4'h7: code = KEY_B;
            4'h8: code = KEY_7;
            4'h9: code = KEY_8;
            4'hA: code = KEY_9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;
            4'hD: code = KEY_0;
            4'hE: code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/teclado_debounce.sv
// Scan-end driven debounce FSM for the keypad, with optional auto-repeat
// strobe when TECLADO_REPEAT_EN is defined.
//
// state        | meaning
// REL          | no key accepted, waiting for a scan with a hit
// PRESS_PEND   | candidate seen on cnt consecutive scans
// PRESSED      | key accepted, keypad_pressed high
// RELEASE_PEND | accepted key missing for cnt consecutive scans
module teclado_debounce
    import juego_pkg::*;
#(
    parameter int DEB_SCANS    = 10,
    parameter int REPEAT_SCANS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_end,
    input  logic       scan_valid,
    input  logic [4:0] scan_code,
    output logic [4:0] key,
    output logic       keypad_pressed,
    output logic       key_strobe
);

    localparam int CNT_W = $clog2(DEB_SCANS + 1);

    deb_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [4:0]       cand, cand_n, key_n;
    logic             pressed_n, strobe_n;

`ifdef TECLADO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    logic [REP_W-1:0] rep, rep_n;
`endif

    assign cnt_inc = (int'(cnt) >= DEB_SCANS) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= REL;
            cnt            <= '0;
            cand           <= '0;
            key            <= '0;
            keypad_pressed <= 1'b0;
            key_strobe     <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            cand           <= cand_n;
            key            <= key_n;
            keypad_pressed <= pressed_n;
            key_strobe     <= strobe_n;
        end
    end

`ifdef TECLADO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) rep <= '0;
        else     rep <= rep_n;
    end
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cand_n    = cand;
        key_n     = key;
        pressed_n = keypad_pressed;
        strobe_n  = 1'b0;
`ifdef TECLADO_REPEAT_EN
        rep_n     = rep;
`endif
        if (scan_end) begin
            case (state)
                REL: begin
                    if (scan_valid) begin
                        cand_n = scan_code;
                        cnt_n  = CNT_W'(1);
                        if (DEB_SCANS <= 1) begin
                            state_n   = PRESSED;
                            key_n     = scan_code;
                            pressed_n = 1'b1;
                            strobe_n  = 1'b1;
`ifdef TECLADO_REPEAT_EN
                            rep_n     = '0;
`endif
                        end else begin
                            state_n = PRESS_PEND;
                        end
                    end
                end
                PRESS_PEND: begin
                    if (!scan_valid) begin
                        state_n = REL;
                    end else if (scan_code != cand) begin
                        cand_n = scan_code;
                        cnt_n  = CNT_W'(1);
                    end else if (int'(cnt_inc) >= DEB_SCANS) begin
                        state_n   = PRESSED;
                        key_n     = cand;
                        pressed_n = 1'b1;
                        strobe_n  = 1'b1;
`ifdef TECLADO_REPEAT_EN
                        rep_n     = '0;
`endif
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!scan_valid || scan_code != key) begin
                        cnt_n = CNT_W'(1);
                        if (DEB_SCANS <= 1) begin
                            state_n   = REL;
                            pressed_n = 1'b0;
                        end else begin
                            state_n = RELEASE_PEND;
                        end
                    end else begin
`ifdef TECLADO_REPEAT_EN
                        if (int'(rep) + 1 >= REPEAT_SCANS) begin
                            rep_n    = '0;
                            strobe_n = 1'b1;
                        end else begin
                            rep_n = rep + REP_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    if (scan_valid && scan_code == key) begin
                        state_n = PRESSED;
`ifdef TECLADO_REPEAT_EN
                        rep_n   = '0;
`endif
                    end else if (int'(cnt_inc) >= DEB_SCANS) begin
                        state_n   = REL;
                        pressed_n = 1'b0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/teclado_matricial.sv
// 4x4 keypad scanner: row synchronizer, column scanner and key encoder feeding
// the debounce FSM. Define TECLADO_REPEAT_EN to enable auto-repeat strobes.
module teclado_matricial
    import juego_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEB_SCANS    = 10,
    parameter int REPEAT_SCANS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [4:0] key,
    output logic       keypad_pressed,
    output logic       key_strobe
);

    localparam int WIN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [3:0]       row_meta, row_sync;
    logic [WIN_W-1:0] win_cnt;
    logic [1:0]       col_idx;
    logic             hit_valid;
    logic [4:0]       hit_code;

    logic             win_end, col_hit, take, scan_end, scan_valid;
    logic [1:0]       col_row;
    logic [4:0]       scan_code;

    assign win_end  = (win_cnt == WIN_W'(SCAN_DIV - 1));
    assign col_hit  = (row_sync != 4'hF);
    assign scan_end = win_end && (col_idx == 2'd3);
    assign col      = ~(4'b0001 << col_idx);

    always_comb begin
        casez (row_sync)
            4'b???0: col_row = 2'd0;
            4'b??01: col_row = 2'd1;
            4'b?011: col_row = 2'd2;
            4'b0111: col_row = 2'd3;
            default: col_row = 2'd0;
        endcase
    end

    // col0 opens a fresh scan; later columns only fill in when nothing was found yet.
    assign take       = col_hit && (col_idx == 2'd0 || !hit_valid);
    assign scan_valid = take ? 1'b1 : ((col_idx == 2'd0) ? 1'b0 : hit_valid);
    assign scan_code  = take ? key_code(col_row, col_idx) : hit_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            win_cnt   <= '0;
            col_idx   <= 2'd0;
            hit_valid <= 1'b0;
            hit_code  <= '0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            if (win_end) begin
                win_cnt   <= '0;
                col_idx   <= col_idx + 2'd1;
                hit_valid <= scan_valid;
                hit_code  <= scan_code;
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
            end
        end
    end

    teclado_debounce #(
        .DEB_SCANS    (DEB_SCANS),
        .REPEAT_SCANS (REPEAT_SCANS)
    ) u_debounce (
        .clk            (clk),
        .rst            (rst),
        .scan_end       (scan_end),
        .scan_valid     (scan_valid),
        .scan_code      (scan_code),
        .key            (key),
        .keypad_pressed (keypad_pressed),
        .key_strobe     (key_strobe)
    );

endmodule

// File: doc/teclado_matricial.md
# teclado_matricial

Scanner and debouncer for the 4x4 matrix keypad that drives the hero game. Drives the keypad columns one at a time, samples the rows, and debounces the decoded key over whole scans. Produces the `key` / `keypad_pressed` pair consumed by the movement stage, which reads codes 2 (fly), 6 (jump) and 8 (crouch) while the game FSM is in state `juego`. Adds a one-cycle `key_strobe` for menu-level consumers (`hola` / `personaje` screens).

## Interface

Parameters:
- `SCAN_DIV`, default 50000: clock cycles each column is driven (1 ms at 50 MHz); must be ≥ 4.
- `DEB_SCANS`, default 10: consecutive full scans with identical result needed to accept a press or a release; ≥ 1.
- `REPEAT_SCANS`, default 250: full scans between auto-repeat strobes; used only with the macro.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `row`  in  4  keypad rows, active-low, externally pulled up; asynchronous.
- `col`  out  4  column drive, active-low, exactly one bit low at all times.
- `key`  out  5  debounced key code; holds last accepted code after release.
- `keypad_pressed`  out  1  level, high while the accepted key is held.
- `key_strobe`  out  1  one-cycle pulse when a key is accepted (and on repeat).

## Operation

- Layout and codes: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = * 0 # D (col0..col3 left to right).
  - Digits map to their value.
  - A = 10, B = 11, C = 12, D = 13, * = 14, # = 15.
  - Codes 16..31 are never produced.
- `row` passes through a 2-FF synchronizer before any use.
- Scan FSM: the column index runs 0 → 1 → 2 → 3 → 0.
  - Each column is held low for `SCAN_DIV` cycles.
  - The synchronized rows are sampled on the last cycle of each window.
  - The lowest row with a low bit gives the candidate for that column.
  - Across one full scan (col0..col3), the first hit in scan order (col0 first, then row0 first) wins. Any other simultaneously pressed keys are ignored.
  - End of col3 window = scan end. The scan result is either one code or "none".
- Debounce FSM, evaluated only at scan end:
  - REL: the result is a code → go to PRESS_PEND, latch candidate, count = 1.
  - PRESS_PEND:
    - Same code → count++.
    - Different code → restart with the new code, count = 1.
    - None → back to REL.
    - When count reaches `DEB_SCANS` → go to PRESSED, set `key`, raise `keypad_pressed`, pulse `key_strobe`.
  - PRESSED: any scan result other than the accepted code (none or a different key) → RELEASE_PEND, count = 1.
  - RELEASE_PEND:
    - Accepted code seen again → back to PRESSED, no strobe.
    - Otherwise count++.
    - At `DEB_SCANS` → REL, drop `keypad_pressed`.
  - A new key is accepted only after the release is confirmed.
- `DEB_SCANS` = 1 is legal: a press is accepted at the first scan end that shows it.

## Timing

- Reset values: `col` = 4'b1110 (col0), scan counter 0, debounce state REL, `key` = 5'd0, `keypad_pressed` = 0, `key_strobe` = 0, synchronizer flops = 4'b1111.
- Reset asserted mid-scan or mid-debounce: the next cycle is exactly the reset state. No strobe is emitted from a partial count.
- Full scan period = 4·`SCAN_DIV` cycles.
- Sample-to-output latency: `key`, `keypad_pressed` and `key_strobe` update on the cycle after the scan-end sample edge, all together.
- Minimum press latency (key already stable) = `DEB_SCANS` full scans, plus up to one partial scan, plus 2 synchronizer cycles.
- Release latency = `DEB_SCANS` full scans.
- `key_strobe` is never high on two consecutive cycles. `key` never changes while `keypad_pressed` is high.
- Counters: scan-window counter is `$clog2(SCAN_DIV)` bits. Scan counters saturate and never wrap.

## Configuration

- Macro `TECLADO_REPEAT_EN` defined: while in PRESSED, `key_strobe` re-pulses every `REPEAT_SCANS` full scans. The repeat counter clears on entry to PRESSED and on return from RELEASE_PEND.
- Macro not defined: exactly one strobe per accepted press. `REPEAT_SCANS` is ignored and no repeat counter is synthesized.

## Structure

- Shared package `juego_pkg` holds:
  - Key code constants `KEY_0`..`KEY_9`, `KEY_A`..`KEY_D`, `KEY_STAR`, `KEY_HASH`. The movement stage compares against `KEY_2`, `KEY_6`, `KEY_8`.
  - Debounce state typedef (REL, PRESS_PEND, PRESSED, RELEASE_PEND).
  - Game state constants (apagado = 0, hola = 1, personaje = 2, juego = 3).
- One sub-module, `teclado_debounce`: the scan-end-driven debounce FSM plus the repeat logic. The top level keeps the synchronizer, column scanner and row/col encoder.

## Test plan

Use `SCAN_DIV` = 4, `DEB_SCANS` = 3, `REPEAT_SCANS` = 5 (scan = 16 cycles).

- Hold key 6 (row1 low when col2 is driven) from reset release → `keypad_pressed` rises at the end of the 3rd full scan (~50 cycles), `key` = 6, one `key_strobe`.
- Hold key 8 with a 1-scan bounce (row released for 1 scan at scan 2) → acceptance is delayed to 3 clean consecutive scans. No strobe before that.
- Release while pressed → `keypad_pressed` falls after 3 none-scans. `key` stays 8. A 2-scan release glitch returns to PRESSED with no new strobe.
- Press 2 and 5 together → `key` = 2 (col1 row0 precedes col1 row1). Press 1 and 2 → `key` = 1.
- Assert `rst` mid PRESS_PEND, then hold key 2 → all outputs at reset values next cycle, `col` = 1110, full 3-scan latency restarts.
- With `TECLADO_REPEAT_EN`, hold # for 20 scans → strobes at acceptance and every 5 scans after. Without the macro → exactly one strobe.
